// File: rtl/auth_pkg.sv
// Shared definitions for the HB authentication datapath: verifier FSM encoding
// and the default session sizing common to the mac stage and the prover model.
package auth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DECIDE  = 2'd2,
      ST_DONE    = 2'd3
   } verifier_state_t;

   localparam int DEF_NUM_ROUNDS = 128;
   localparam int DEF_THRESHOLD  = 32;

endpackage

// File: rtl/hb_err_counter.sv
// Round and mismatch counters for one authentication session.
// last_round flags that the next enabled round completes the session.
module hb_err_counter #(
   parameter  int NUM_ROUNDS = 128,
   localparam int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             mismatch,
   output logic             last_round,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

   logic [CNT_W-1:0] round_cnt_reg;
   logic [CNT_W-1:0] err_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_cnt_reg <= '0;
         err_count_reg <= '0;
      end else if (clr) begin
         round_cnt_reg <= '0;
         err_count_reg <= '0;
      end else if (en) begin
         round_cnt_reg <= round_cnt_reg + CNT_W'(1);
         err_count_reg <= err_count_reg + CNT_W'(mismatch);
      end
   end

   assign last_round = (round_cnt_reg == LAST_IDX);
   assign err_count  = err_count_reg;

endmodule

// File: rtl/hb_round_verifier.sv
// HB reader-side verifier: counts sum_bit/resp_bit disagreements over a session
// and accepts when the total stays within THRESHOLD.
module hb_round_verifier
   import auth_pkg::*;
#(
   parameter  int NUM_ROUNDS = DEF_NUM_ROUNDS,
   parameter  int THRESHOLD  = DEF_THRESHOLD,
   localparam int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             round_valid,
   input  logic             sum_bit,
   input  logic             resp_bit,
   output logic             round_ready,
   output logic             busy,
   output logic             done,
   output logic             accept,
   output logic [CNT_W-1:0] err_count
);

   // A threshold at or above the round count can never be exceeded, so clamp it
   // to NUM_ROUNDS to keep the compare within the counter width.
   localparam logic [CNT_W-1:0] THR_C = (THRESHOLD >= NUM_ROUNDS) ? CNT_W'(NUM_ROUNDS)
                                                                   : CNT_W'(THRESHOLD);

   verifier_state_t state_reg, state_next;
   logic            accept_reg, accept_next;
   logic            round_ready_reg, busy_reg, done_reg;
   logic            cnt_clr, cnt_en, last_round;
   logic [CNT_W-1:0] err_cnt;

   hb_err_counter #(
      .NUM_ROUNDS (NUM_ROUNDS)
   ) u_err_counter (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr),
      .en         (cnt_en),
      .mismatch   (sum_bit ^ resp_bit),
      .last_round (last_round),
      .err_count  (err_cnt)
   );

   always_comb begin
      state_next  = state_reg;
      accept_next = accept_reg;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               cnt_clr     = 1'b1;
               accept_next = 1'b0;
               state_next  = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (abort) begin
               accept_next = 1'b0;
               state_next  = ST_IDLE;
            end else if (round_valid) begin
               cnt_en = 1'b1;
               if (last_round) begin
                  state_next = ST_DECIDE;
               end
            end
         end
         ST_DECIDE: begin
            if (abort) begin
               accept_next = 1'b0;
               state_next  = ST_IDLE;
            end else begin
               accept_next = (err_cnt <= THR_C);
               state_next  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Status flags are registered from the next state so they line up with state_reg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         accept_reg      <= 1'b0;
         round_ready_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         accept_reg      <= accept_next;
         round_ready_reg <= (state_next == ST_COLLECT);
         busy_reg        <= (state_next != ST_IDLE);
         done_reg        <= (state_next == ST_DONE);
      end
   end

   assign round_ready = round_ready_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign accept      = accept_reg;
   assign err_count   = err_cnt;

endmodule

// File: tb/tb_hb_round_verifier.sv
// Bench for hb_round_verifier: table of sessions checked against a popcount model,
// plus hand sequences for abort, reset and the long 128-round session.
module tb_hb_round_verifier;

   localparam int NR  = 8;
   localparam int THR = 2;

   logic clk = 1'b0;
   logic rst, start, abort, round_valid, sum_bit, resp_bit;
   logic round_ready, busy, done, accept;
   logic [3:0] err_count;
   logic c_round_ready, c_busy, c_done, c_accept;
   logic [3:0] c_err_count;
   logic b_start, b_abort, b_valid, b_sum, b_resp;
   logic b_round_ready, b_busy, b_done, b_accept;
   logic [7:0] b_err_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hb_round_verifier #(.NUM_ROUNDS(NR), .THRESHOLD(THR)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .round_valid(round_valid),
      .sum_bit(sum_bit), .resp_bit(resp_bit), .round_ready(round_ready), .busy(busy),
      .done(done), .accept(accept), .err_count(err_count));

   hb_round_verifier #(.NUM_ROUNDS(NR), .THRESHOLD(NR)) dut_lax (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .round_valid(round_valid),
      .sum_bit(sum_bit), .resp_bit(resp_bit), .round_ready(c_round_ready), .busy(c_busy),
      .done(c_done), .accept(c_accept), .err_count(c_err_count));

   hb_round_verifier #(.NUM_ROUNDS(128), .THRESHOLD(32)) dut_long (
      .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .round_valid(b_valid),
      .sum_bit(b_sum), .resp_bit(b_resp), .round_ready(b_round_ready), .busy(b_busy),
      .done(b_done), .accept(b_accept), .err_count(b_err_count));

   typedef struct {
      string      name;
      logic [7:0] mask;      // bit i set -> round i+1 mismatches
      int         gap;       // idle cycles before each valid round
      bit         mid_start;
      int         exp_err;
      bit         exp_acc;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int model_err(input logic [7:0] mask);
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(mask[i]);
      return n;
   endfunction

   task automatic run_session(input vec_t v);
      start = 1'b1;
      step();
      start = 1'b0;
      check({v.name, ".busy_start"}, 32'(busy), 32'd1);
      check({v.name, ".ready_start"}, 32'(round_ready), 32'd1);
      for (int i = 0; i < NR; i++) begin
         for (int g = 0; g < v.gap; g++) begin
            round_valid = 1'b0;
            sum_bit     = 1'($urandom);
            resp_bit    = 1'($urandom);
            start       = v.mid_start && (i == 3) && (g == 0);
            step();
            start = 1'b0;
            check({v.name, ".gap_ready"}, 32'(round_ready), 32'd1);
         end
         round_valid = 1'b1;
         sum_bit     = 1'($urandom);
         resp_bit    = sum_bit ^ v.mask[i];
         start       = v.mid_start && (i == 5);
         step();
         start       = 1'b0;
         round_valid = 1'b0;
         if (i < NR - 1) begin
            check({v.name, ".no_early"}, 32'({round_ready, done}), 32'b10);
         end
      end
      check({v.name, ".decide_done"}, 32'(done), 32'd0);
      check({v.name, ".decide_flags"}, 32'({busy, round_ready}), 32'b10);
      step();
      check({v.name, ".done"}, 32'(done), 32'd1);
      check({v.name, ".accept"}, 32'(accept), 32'(v.exp_acc));
      check({v.name, ".err"}, 32'(err_count), 32'(v.exp_err));
      check({v.name, ".lax_accept"}, 32'({c_done, c_accept}), 32'b11);
      check({v.name, ".lax_err"}, 32'(c_err_count), 32'(v.exp_err));
      step();
      check({v.name, ".after_done"}, 32'({done, busy}), 32'b00);
      check({v.name, ".accept_hold"}, 32'(accept), 32'(v.exp_acc));
      check({v.name, ".err_hold"}, 32'(err_count), 32'(v.exp_err));
      $display("session %-12s mask=%02h gap=%0d mid_start=%0b err=%0d accept=%0b",
               v.name, v.mask, v.gap, v.mid_start, err_count, accept);
   endtask

   task automatic feed_rounds(input int n, input logic [7:0] mask);
      for (int i = 0; i < n; i++) begin
         round_valid = 1'b1;
         sum_bit     = 1'($urandom);
         resp_bit    = sum_bit ^ mask[i];
         step();
      end
      round_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; round_valid = 1'b0;
      sum_bit = 1'b0; resp_bit = 1'b0;
      b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_sum = 1'b0; b_resp = 1'b0;

      vecs[0] = '{"clean",       8'h00, 0, 1'b0, 0, 1'b1};
      vecs[1] = '{"two_mis",     8'h21, 0, 1'b0, 2, 1'b1};
      vecs[2] = '{"three_mis",   8'h91, 0, 1'b0, 3, 1'b0};
      vecs[3] = '{"sparse_ends", 8'h81, 2, 1'b0, 2, 1'b1};
      vecs[4] = '{"mid_start",   8'h04, 1, 1'b1, 1, 1'b1};
      for (int r = 5; r < 11; r++) begin
         vecs[r].name      = $sformatf("rand%0d", r);
         vecs[r].mask      = 8'($urandom);
         vecs[r].gap       = int'($urandom_range(0, 2));
         vecs[r].mid_start = 1'($urandom);
         vecs[r].exp_err   = model_err(vecs[r].mask);
         vecs[r].exp_acc   = (vecs[r].exp_err <= THR);
      end

      step();
      check("reset.outputs", 32'({round_ready, busy, done, accept}), 32'd0);
      check("reset.err", 32'(err_count), 32'd0);
      rst = 1'b0;
      step();

      for (int r = 0; r < 11; r++) run_session(vecs[r]);

      // round_valid in IDLE must not touch the held result
      for (int i = 0; i < 3; i++) begin
         round_valid = 1'b1; sum_bit = 1'b1; resp_bit = 1'b0;
         step();
         check("idle_valid.err_hold", 32'(err_count), 32'(vecs[10].exp_err));
         check("idle_valid.busy", 32'(busy), 32'd0);
      end
      round_valid = 1'b0;

      // abort after 4 rounds; the aborting cycle also carries a mismatching round
      start = 1'b1; step(); start = 1'b0;
      feed_rounds(4, 8'h02);
      abort = 1'b1; round_valid = 1'b1; sum_bit = 1'b1; resp_bit = 1'b0;
      step();
      abort = 1'b0; round_valid = 1'b0;
      check("abort_collect.flags", 32'({busy, round_ready, done, accept}), 32'd0);
      check("abort_collect.err", 32'(err_count), 32'd1);
      step();
      check("abort_collect.no_done", 32'(done), 32'd0);
      $display("session abort_collect err=%0d accept=%0b", err_count, accept);
      run_session(vecs[0]);

      // abort during DECIDE: no decision, no done
      start = 1'b1; step(); start = 1'b0;
      feed_rounds(NR, 8'h00);
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_decide.flags", 32'({busy, done, accept}), 32'd0);
      step();
      check("abort_decide.no_done", 32'(done), 32'd0);
      $display("session abort_decide err=%0d accept=%0b", err_count, accept);

      // abort during DONE is ignored
      start = 1'b1; step(); start = 1'b0;
      feed_rounds(NR, 8'h00);
      step();
      check("abort_done.done", 32'(done), 32'd1);
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_done.accept_kept", 32'({busy, done, accept}), 32'b001);
      $display("session abort_done err=%0d accept=%0b", err_count, accept);

      // start and abort together in IDLE: start wins
      start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
      check("start_abort.busy", 32'({busy, round_ready}), 32'b11);
      check("start_abort.accept_clr", 32'(accept), 32'd0);

      // asynchronous reset between edges while collecting
      feed_rounds(3, 8'h07);
      #2 rst = 1'b1;
      #1;
      check("async_rst.flags", 32'({round_ready, busy, done, accept}), 32'd0);
      check("async_rst.err", 32'(err_count), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("async_rst.no_done", 32'({done, busy}), 32'd0);
      $display("session async_rst err=%0d accept=%0b", err_count, accept);

      // 128-round session with every round mismatching
      b_start = 1'b1; step(); b_start = 1'b0;
      for (int i = 0; i < 128; i++) begin
         b_valid = 1'b1; b_sum = 1'($urandom); b_resp = ~b_sum;
         step();
      end
      b_valid = 1'b0;
      check("long.decide_done", 32'(b_done), 32'd0);
      step();
      check("long.done", 32'(b_done), 32'd1);
      check("long.err", 32'(b_err_count), 32'd128);
      check("long.accept", 32'(b_accept), 32'd0);
      step();
      check("long.idle", 32'({b_busy, b_done}), 32'd0);
      $display("session long128 err=%0d accept=%0b", b_err_count, b_accept);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
